job_loader: RTL and testbench



---
 rtl/job_loader_pkg.sv | 35 +++
 rtl/job_word_packer.sv | 70 +++++++
 rtl/job_loader.sv | 180 ++++++++++++++++++
 tb/tb_job_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/job_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : job_loader_pkg
// Description : Shared job geometry, FSM state types and response codes.
// Revision    : 1.0
// ============================================================================
package job_loader_pkg;

   localparam int MID_WORDS  = 8;
   localparam int HEAD_WORDS = 16;
   localparam int JOB_WORDS  = MID_WORDS + HEAD_WORDS;
   localparam int JOB_BYTES  = 4 * JOB_WORDS;

   localparam int WIDX_W = $clog2(JOB_WORDS + 1);
   // Sized for the optional trailing checksum byte as well
   localparam int BCNT_W = $clog2(JOB_BYTES + 2);

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      START  = 2'd1,
      STREAM = 2'd2
   } load_state_t;

   typedef enum logic [1:0] {
      C_IDLE      = 2'd0,
      C_WAIT_SLOT = 2'd1,
      C_HOLD      = 2'd2
   } claim_state_t;

   localparam logic [1:0] RESP_NONE   = 2'b00;
   localparam logic [1:0] RESP_ACCEPT = 2'b01;
   localparam logic [1:0] RESP_STALE  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/job_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : job_word_packer
// Description : Packs host bytes big-endian into 32-bit job words; with
//               JOB_LOADER_CHECKSUM_EN also checks a trailing XOR byte.
// Revision    : 1.0
// ============================================================================
module job_word_packer
   import job_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        i_byte,
   input  logic              i_accept,
   output logic [31:0]       o_word,
   output logic              o_word_we,
   output logic [WIDX_W-1:0] o_word_idx,
   output logic              o_last
`ifdef JOB_LOADER_CHECKSUM_EN
   ,
   output logic              o_cks_ok
`endif
);

`ifdef JOB_LOADER_CHECKSUM_EN
   localparam int TOTAL_BYTES = JOB_BYTES + 1;
`else
   localparam int TOTAL_BYTES = JOB_BYTES;
`endif
   localparam logic [BCNT_W-1:0] c_LAST = BCNT_W'(TOTAL_BYTES - 1);

   logic [BCNT_W-1:0] r_cnt;
   logic [23:0]       r_shift;

   assign o_word     = {r_shift, i_byte};
   assign o_word_we  = i_accept && (r_cnt[1:0] == 2'b11);
   assign o_word_idx = r_cnt[BCNT_W-1:2];
   assign o_last     = i_accept && (r_cnt == c_LAST);

`ifdef JOB_LOADER_CHECKSUM_EN
   logic [7:0] r_xor;
   // Checksum byte matches when it equals the XOR of all payload bytes
   assign o_cks_ok = (r_xor == i_byte);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_shift <= '0;
`ifdef JOB_LOADER_CHECKSUM_EN
         r_xor   <= '0;
`endif
      end else if (i_accept) begin
         r_shift <= {r_shift[15:0], i_byte};
         if (o_last) begin
            r_cnt <= '0;
`ifdef JOB_LOADER_CHECKSUM_EN
            r_xor <= '0;
`endif
         end else begin
            r_cnt <= r_cnt + 1'b1;
`ifdef JOB_LOADER_CHECKSUM_EN
            r_xor <= r_xor ^ i_byte;
`endif
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/job_loader.sv
`default_nettype none
// ============================================================================
// Module      : job_loader
// Description : Host job buffer/streamer for the SHA core plus solution
//               claim handshake and one-entry nonce slot.
//               Optional feature macro: JOB_LOADER_CHECKSUM_EN.
// Revision    : 1.0
// ============================================================================
module job_loader
   import job_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  host_data,
   input  logic        host_valid,
   output logic        host_ready,
   output logic        start_found,
   output logic [31:0] core_data,
   input  logic        sol_claim,
   input  logic [31:0] core_nonce,
   output logic [1:0]  sol_response,
   output logic [31:0] nonce,
   output logic        nonce_valid,
   input  logic        nonce_ready,
   output logic        job_err
);

   load_state_t       r_load_state;
   claim_state_t      r_claim_state;
   logic              r_host_ready;
   logic              r_start_found;
   logic [31:0]       r_core_data;
   logic [WIDX_W-1:0] r_wcnt;
   logic [1:0]        r_sol_response;
   logic [31:0]       r_nonce;
   logic              r_nonce_valid;
   logic [31:0]       r_buf [JOB_WORDS];

   logic              w_accept;
   logic [31:0]       w_word;
   logic              w_word_we;
   logic [WIDX_W-1:0] w_word_idx;
   logic              w_last;
   logic              w_job_ok;
   logic              w_busy;

   assign w_accept = host_valid && r_host_ready;
   assign w_busy   = (r_load_state != LOAD);

   job_word_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .i_byte     (host_data),
      .i_accept   (w_accept),
      .o_word     (w_word),
      .o_word_we  (w_word_we),
      .o_word_idx (w_word_idx),
      .o_last     (w_last)
`ifdef JOB_LOADER_CHECKSUM_EN
      ,
      .o_cks_ok   (w_job_ok)
`endif
   );

`ifdef JOB_LOADER_CHECKSUM_EN
   logic r_job_err;
   assign job_err = r_job_err;
`else
   assign w_job_ok = 1'b1;
   assign job_err  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < JOB_WORDS; i++) r_buf[i] <= '0;
      end else if (w_word_we) begin
         r_buf[w_word_idx] <= w_word;
      end
   end

   // Load FSM: LOAD collects bytes, START pulses the core, STREAM replays words
   always_ff @(posedge clk) begin
      if (rst) begin
         r_load_state  <= LOAD;
         r_host_ready  <= 1'b1;
         r_start_found <= 1'b0;
         r_core_data   <= '0;
         r_wcnt        <= '0;
`ifdef JOB_LOADER_CHECKSUM_EN
         r_job_err     <= 1'b0;
`endif
      end else begin
`ifdef JOB_LOADER_CHECKSUM_EN
         r_job_err <= 1'b0;
`endif
         case (r_load_state)
            LOAD: begin
               if (w_last) begin
                  if (w_job_ok) begin
                     r_load_state  <= START;
                     r_host_ready  <= 1'b0;
                     r_start_found <= 1'b1;
                  end else begin
`ifdef JOB_LOADER_CHECKSUM_EN
                     r_job_err <= 1'b1;
`endif
                  end
               end
            end
            START: begin
               r_start_found <= 1'b0;
               r_core_data   <= r_buf[0];
               r_wcnt        <= WIDX_W'(1);
               r_load_state  <= STREAM;
            end
            STREAM: begin
               if (r_wcnt == WIDX_W'(JOB_WORDS)) begin
                  r_core_data  <= '0;
                  r_wcnt       <= '0;
                  r_host_ready <= 1'b1;
                  r_load_state <= LOAD;
               end else begin
                  r_core_data <= r_buf[r_wcnt];
                  r_wcnt      <= r_wcnt + 1'b1;
               end
            end
            default: begin
               r_load_state  <= LOAD;
               r_host_ready  <= 1'b1;
               r_start_found <= 1'b0;
               r_core_data   <= '0;
               r_wcnt        <= '0;
            end
         endcase
      end
   end

   // Claim FSM and result slot; emptiness is judged on the registered flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_claim_state  <= C_IDLE;
         r_sol_response <= RESP_NONE;
         r_nonce        <= '0;
         r_nonce_valid  <= 1'b0;
      end else begin
         r_sol_response <= RESP_NONE;
         if (r_nonce_valid && nonce_ready) r_nonce_valid <= 1'b0;
         case (r_claim_state)
            C_IDLE, C_WAIT_SLOT: begin
               if (!sol_claim) begin
                  r_claim_state <= C_IDLE;
               end else if (w_busy) begin
                  r_sol_response <= RESP_STALE;
                  r_claim_state  <= C_HOLD;
               end else if (!r_nonce_valid) begin
                  r_nonce        <= core_nonce;
                  r_nonce_valid  <= 1'b1;
                  r_sol_response <= RESP_ACCEPT;
                  r_claim_state  <= C_HOLD;
               end else begin
                  r_claim_state <= C_WAIT_SLOT;
               end
            end
            C_HOLD: begin
               if (!sol_claim) r_claim_state <= C_IDLE;
            end
            default: r_claim_state <= C_IDLE;
         endcase
      end
   end

   assign host_ready   = r_host_ready;
   assign start_found  = r_start_found;
   assign core_data    = r_core_data;
   assign sol_response = r_sol_response;
   assign nonce        = r_nonce;
   assign nonce_valid  = r_nonce_valid;

endmodule
`default_nettype wire

// File: tb/tb_job_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_job_loader
// Description : Directed/random bench for job_loader with a byte-level job
//               model and spec-derived claim/slot expectations.
// Revision    : 1.0
// ============================================================================
module tb_job_loader;

   localparam int NWORDS = 24;
   localparam int NBYTES = 96;
`ifdef JOB_LOADER_CHECKSUM_EN
   localparam int NSEND = NBYTES + 1;
`else
   localparam int NSEND = NBYTES;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  host_data = '0;
   logic        host_valid = 1'b0;
   logic        host_ready;
   logic        start_found;
   logic [31:0] core_data;
   logic        sol_claim = 1'b0;
   logic [31:0] core_nonce = '0;
   logic [1:0]  sol_response;
   logic [31:0] nonce;
   logic        nonce_valid;
   logic        nonce_ready = 1'b0;
   logic        job_err;

   int n_checks = 0;
   int n_errs   = 0;
   logic [7:0] jb [0:NBYTES];

   always #5 clk = ~clk;

   job_loader dut (
      .clk          (clk),
      .rst          (rst),
      .host_data    (host_data),
      .host_valid   (host_valid),
      .host_ready   (host_ready),
      .start_found  (start_found),
      .core_data    (core_data),
      .sol_claim    (sol_claim),
      .core_nonce   (core_nonce),
      .sol_response (sol_response),
      .nonce        (nonce),
      .nonce_valid  (nonce_valid),
      .nonce_ready  (nonce_ready),
      .job_err      (job_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Job model: word k is bytes 4k..4k+3, first byte most significant
   function automatic logic [31:0] exp_word(input int k);
      return {jb[4*k], jb[4*k+1], jb[4*k+2], jb[4*k+3]};
   endfunction

   task automatic build_job(input bit ramp);
      logic [7:0] x;
      x = '0;
      for (int i = 0; i < NBYTES; i++) begin
         jb[i] = ramp ? 8'(i) : 8'($urandom);
         x ^= jb[i];
      end
      jb[NBYTES] = x;
   endtask

   task automatic send_bytes(input int nb, input bit gaps);
      for (int i = 0; i < nb; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            host_valid = 1'b0;
            tick();
         end
         host_valid = 1'b1;
         host_data  = jb[i];
         tick();
      end
      host_valid = 1'b0;
   endtask

   // Called at T+1 (cycle after the final byte was accepted)
   task automatic check_stream(input string tag);
      check({tag, "_start"}, 32'(start_found), 32'd1);
      check({tag, "_rdy_lo"}, 32'(host_ready), 32'd0);
      check({tag, "_cd_idle"}, core_data, 32'd0);
      for (int k = 0; k < NWORDS; k++) begin
         tick();
         check($sformatf("%s_w%0d", tag, k), core_data, exp_word(k));
         if (k == 0) check({tag, "_start_lo"}, 32'(start_found), 32'd0);
      end
      tick();
      check({tag, "_rdy_back"}, 32'(host_ready), 32'd1);
      check({tag, "_cd_zero"}, core_data, 32'd0);
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      check("rst_ready", 32'(host_ready), 32'd1);
      check("rst_start", 32'(start_found), 32'd0);
      check("rst_cd", core_data, 32'd0);
      check("rst_resp", 32'(sol_response), 32'd0);
      check("rst_nonce", nonce, 32'd0);
      check("rst_nvalid", 32'(nonce_valid), 32'd0);
      check("rst_jerr", 32'(job_err), 32'd0);

      // Ramp job, back-to-back bytes
      build_job(1'b1);
      send_bytes(NSEND, 1'b0);
      check_stream("ramp");

      // Random jobs with random idle gaps
      for (int j = 0; j < 2; j++) begin
         build_job(1'b0);
         send_bytes(NSEND, 1'b1);
         check_stream($sformatf("rnd%0d", j));
      end

      // Accepted claim on an idle loader with an empty slot
      sol_claim  = 1'b1;
      core_nonce = 32'hDEADBEEF;
      tick();
      core_nonce = 32'h0BADF00D;
      check("acc_resp", 32'(sol_response), 32'd1);
      check("acc_nonce", nonce, 32'hDEADBEEF);
      check("acc_nvalid", 32'(nonce_valid), 32'd1);
      tick();
      check("acc_once1", 32'(sol_response), 32'd0);
      tick();
      check("acc_once2", 32'(sol_response), 32'd0);
      check("acc_hold_nonce", nonce, 32'hDEADBEEF);
      sol_claim = 1'b0;
      tick();

      // Claim waits on a full slot, accepted two cycles after the drain
      sol_claim  = 1'b1;
      core_nonce = 32'h12345678;
      tick();
      check("wait_resp0", 32'(sol_response), 32'd0);
      tick();
      check("wait_resp1", 32'(sol_response), 32'd0);
      check("wait_nonce", nonce, 32'hDEADBEEF);
      nonce_ready = 1'b1;
      tick();
      nonce_ready = 1'b0;
      check("drain_nvalid", 32'(nonce_valid), 32'd0);
      check("drain_resp", 32'(sol_response), 32'd0);
      tick();
      check("late_resp", 32'(sol_response), 32'd1);
      check("late_nonce", nonce, 32'h12345678);
      check("late_nvalid", 32'(nonce_valid), 32'd1);
      sol_claim = 1'b0;
      tick();

      // Claim waiting during LOAD on a full slot is answered stale at job start
      sol_claim  = 1'b1;
      core_nonce = 32'hCAFEF00D;
      tick();
      check("stl_wait", 32'(sol_response), 32'd0);
      build_job(1'b0);
      send_bytes(NSEND, 1'b1);
      check("stl_start", 32'(start_found), 32'd1);
      check("stl_resp_t1", 32'(sol_response), 32'd0);
      tick();
      check("stl_resp", 32'(sol_response), 32'd2);
      check("stl_nonce", nonce, 32'h12345678);
      check("stl_nvalid", 32'(nonce_valid), 32'd1);
      check("stl_w0", core_data, exp_word(0));
      sol_claim = 1'b0;
      tick();
      check("stl_once", 32'(sol_response), 32'd0);

      // Fresh claim raised mid-stream: stale, slot untouched
      sol_claim  = 1'b1;
      core_nonce = 32'h55AA55AA;
      tick();
      check("strm_resp", 32'(sol_response), 32'd2);
      check("strm_nonce", nonce, 32'h12345678);
      check("strm_nvalid", 32'(nonce_valid), 32'd1);
      sol_claim = 1'b0;
      for (int i = 0; i < 22; i++) tick();
      check("strm_rdy_back", 32'(host_ready), 32'd1);

      // Reset after 50 bytes with a full slot; then a clean job
      build_job(1'b0);
      send_bytes(50, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_nvalid", 32'(nonce_valid), 32'd0);
      check("mrst_nonce", nonce, 32'd0);
      check("mrst_ready", 32'(host_ready), 32'd1);
      build_job(1'b0);
      send_bytes(NSEND, 1'b1);
      check_stream("postrst");

`ifdef JOB_LOADER_CHECKSUM_EN
      // Bad checksum drops the job; the following good job runs normally
      build_job(1'b0);
      jb[NBYTES] = jb[NBYTES] ^ 8'h5A;
      send_bytes(NSEND, 1'b1);
      check("cks_err", 32'(job_err), 32'd1);
      check("cks_nostart", 32'(start_found), 32'd0);
      check("cks_ready", 32'(host_ready), 32'd1);
      tick();
      check("cks_err_lo", 32'(job_err), 32'd0);
      check("cks_nostart2", 32'(start_found), 32'd0);
      build_job(1'b0);
      send_bytes(NSEND, 1'b1);
      check_stream("cks_good");
`else
      check("jerr_tied", 32'(job_err), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
